bl_order_reorder: RTL and testbench
===================================

// Module: bl_order_reorder
// PURPOSE
//  X-engine output-side companion of the baseline order generator. Accepts the
//  correlator product stream in generator order, tags each product with its
//  antenna pair, and discards the duplicated N/2-separation baselines. Conjugates
//  products so that every baseline is held as i<=j, and double-buffers one frame.
//  Replays each completed frame in canonical triangular order (j=0..N-1, i=0..j)
//  to the vector accumulator.
// PARAMETERS
//  N_ANTS   16  antennas; power of 2, >=4. ANT_BITS=log2(N_ANTS)
//  DATA_W   18  width of each of re/im; in_data = {re,im}, two's complement
//  Derived: FRAME_LEN=N_ANTS*(N_ANTS/2+1), N_BL=N_ANTS*(N_ANTS+1)/2, BL_BITS=clog2(N_BL)
// PORTS
//  clk        in   1           single clock, rising edge
//  rst_n      in   1           asynchronous, active-low reset
//  sync       in   1           frame alignment; next in_valid is frame slot 0
//  in_valid   in   1           in_data holds a product this cycle
//  in_data    in   2*DATA_W    product X(a)*conj(X(b)) for the current slot
//  out_valid  out  1           out_* hold one canonical baseline
//  out_data   out  2*DATA_W    X(i)*conj(X(j)), {re,im}
//  out_ant_i  out  ANT_BITS    lower antenna index i
//  out_ant_j  out  ANT_BITS    upper antenna index j (i<=j)
//  out_last   out  1           high with final baseline (i=j=N-1) of a frame
//  ovf_err    out  1           sticky; new readout was required while one was active
// BEHAVIOUR
//  - Reset (rst_n=0): every register cleared; out_* = 0, ovf_err = 0, both banks empty.
//  - Slot tracker: registers a,b,offset advance only on in_valid.
//    sync: b=0, a=N/2, offset=N/2+1. in_valid with a==b: b++, a=offset, offset++.
//    Otherwise a++. All mod N_ANTS. Frame ends at the slot with a==b==N-1.
//  - Stage 1 (registered, +1 clk): d=(a-b) mod N.
//    drop = (d==N/2) && (b>=N/2).
//    conj = a>b; i=min(a,b), j=max(a,b).
//    addr = j*(j+1)/2+i, from a combinational j-term. No DSP is required; widths are small.
//    conj negates im with saturation: -(2^(DATA_W-1)) maps to 2^(DATA_W-1)-1.
//  - Stage 2 (+2 clk): unless drop, write {data} into bank wr_bank at addr.
//    On the final frame slot's write, toggle wr_bank. Mark the old bank full and
//    start its readout.
//  - Readout: addr 0..N_BL-1, one per clk, no backpressure.
//    (i,j) counters run alongside: i++; when i==j, then j++, i=0.
//    RAM read has 1 clk of latency. out_valid first asserts exactly 4 clk after the
//    last accepted in_valid of the frame. It then stays high for N_BL consecutive clk.
//    out_last is high on the N_BL-th.
//  - Bank conflict: a readout takes N_BL < FRAME_LEN clk, so with legal input it
//    always ends first. If a new frame completes while a readout is active: abort
//    the old readout, start the new one, and set ovf_err.
//  - Unwritten addresses never occur in a full frame. Every one of the N_BL baselines
//    is written exactly once per frame.
//  - sync mid-frame: flush the pipeline stages and reinitialise the tracker. Discard
//    the partial frame, so its bank is never read. Abort any active readout: out_valid
//    drops the next clk. ovf_err is held.
//  - sync and in_valid in the same clk: the sample is taken as slot 0 of the new frame.
//  - in_valid gaps: the tracker and pipeline hold, and output timing is counted from
//    the last accepted sample.
// STRUCTURE
//  - Package xeng_pkg: log2/clog2 functions, FRAME_LEN, N_BL, and a tri_idx(j) function.
//  - Sub-module bl_reorder_ram: simple dual-port RAM, depth 2*N_BL, width 2*DATA_W.
//    Address {bank,addr}; synchronous read with 1 clk latency. Infers to BRAM.
//  - The slot tracker duplicates the generator algorithm inline. It must stay
//    bit-for-bit consistent with the generator.
// TESTING
//  1. N_ANTS=4, sync, then 12 in_valid with re=im=k for k=0..11.
//     out re sequence: 2,4,5,0,7,8,1,3,10,11.
//     (i,j) sequence: (0,0)(0,1)(1,1)(0,2)(1,2)(2,2)(0,3)(1,3)(2,3)(3,3).
//     im = -re for re in {0,1,3}. out_last only on the 10th.
//  2. Same as test 1, timing. out_valid first high 4 clk after the 12th in_valid.
//     It stays high for 10 contiguous clk. Slots 6 and 9 (duplicates) never appear.
//  3. N_ANTS=16, 3 back-to-back frames, data = slot number.
//     Each frame gives 136 outputs, and output k carries the correct tri-index
//     mapping. The bank toggles every 144 samples, and ovf_err stays 0.
//  4. Saturation: the input at slot (2,0) has im=-2^17, with DATA_W=18.
//     Output (0,2) shows im = 2^17-1.
//  5. Mid-frame sync, N_ANTS=4: 7 samples, sync, then 12 samples.
//     Only one frame of 10 outputs appears, matching test 1. Asserting sync during
//     a readout stops out_valid next clk.
//  6. rst_n=0 during a readout, asynchronously mid-cycle: all outputs are 0 at once.
//     After release and a full frame, the output matches test 1.

Source files
------------

// File: rtl/xeng_pkg.sv
// Shared helpers for the X-engine baseline reorder path: width math, frame sizes and
// triangular indexing of the (i<=j) baseline space.
package xeng_pkg;

  typedef enum logic {RdIdle, RdRun} rd_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((v >> (r + 1)) != 0) r++;
    return r;
  endfunction

  function automatic int unsigned frame_len(input int unsigned n_ants);
    return n_ants * (n_ants / 2 + 1);
  endfunction

  function automatic int unsigned n_bl(input int unsigned n_ants);
    return n_ants * (n_ants + 1) / 2;
  endfunction

  // Offset of row j in canonical triangular order.
  function automatic int unsigned tri_idx(input int unsigned j);
    return j * (j + 1) / 2;
  endfunction

endpackage

// File: rtl/bl_reorder_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// Address space holds two banks back to back; no reset so it maps onto block RAM.
module bl_reorder_ram #(
  parameter int unsigned DEPTH = 272,
  parameter int unsigned WIDTH = 36,
  parameter int unsigned AW    = 9
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bl_order_reorder.sv
// Tags the correlator product stream with its antenna pair, drops duplicate N/2 baselines,
// folds every product onto i<=j and replays each completed frame in triangular order.
module bl_order_reorder
  import xeng_pkg::*;
#(
  parameter int unsigned N_ANTS = 16,
  parameter int unsigned DATA_W = 18
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sync,
  input  logic                         in_valid,
  input  logic [2*DATA_W-1:0]          in_data,
  output logic                         out_valid,
  output logic [2*DATA_W-1:0]          out_data,
  output logic [log2(N_ANTS)-1:0]      out_ant_i,
  output logic [log2(N_ANTS)-1:0]      out_ant_j,
  output logic                         out_last,
  output logic                         ovf_err
);

  localparam int unsigned ANT_BITS  = log2(N_ANTS);
  localparam int unsigned N_BL      = n_bl(N_ANTS);
  localparam int unsigned BL_BITS   = clog2(N_BL);
  localparam int unsigned RAM_DEPTH = 2 * N_BL;
  localparam int unsigned RAM_AW    = clog2(RAM_DEPTH);

  localparam logic [ANT_BITS-1:0] ANT_ONE  = ANT_BITS'(1);
  localparam logic [ANT_BITS-1:0] ANT_HALF = ANT_BITS'(N_ANTS / 2);
  localparam logic [ANT_BITS-1:0] ANT_OFF0 = ANT_BITS'(N_ANTS / 2 + 1);
  localparam logic [ANT_BITS-1:0] ANT_MAX  = ANT_BITS'(N_ANTS - 1);
  localparam logic [BL_BITS-1:0]  BL_ONE   = BL_BITS'(1);
  localparam logic [BL_BITS-1:0]  BL_LAST  = BL_BITS'(N_BL - 1);
  localparam logic [DATA_W-1:0]   IM_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0]   IM_MAX   = {1'b0, {(DATA_W-1){1'b1}}};

  function automatic logic [RAM_AW-1:0] bank_addr(input logic bank,
                                                  input logic [BL_BITS-1:0] addr);
    return bank ? RAM_AW'(N_BL) + RAM_AW'(addr) : RAM_AW'(addr);
  endfunction

  // Slot tracker: replica of the generator's (a,b) walk; sync reloads it combinationally
  // so a sample arriving with sync is slot 0.
  logic [ANT_BITS-1:0] a_q, b_q, off_q;
  logic [ANT_BITS-1:0] cur_a, cur_b, cur_off;
  logic [ANT_BITS-1:0] nxt_a, nxt_b, nxt_off;

  always_comb begin
    cur_a   = sync ? ANT_HALF : a_q;
    cur_b   = sync ? '0 : b_q;
    cur_off = sync ? ANT_OFF0 : off_q;
    nxt_a   = cur_a + ANT_ONE;
    nxt_b   = cur_b;
    nxt_off = cur_off;
    if (cur_a == cur_b) begin
      nxt_b   = cur_b + ANT_ONE;
      nxt_a   = cur_off;
      nxt_off = cur_off + ANT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      off_q <= '0;
    end else if (in_valid) begin
      a_q   <= nxt_a;
      b_q   <= nxt_b;
      off_q <= nxt_off;
    end else if (sync) begin
      a_q   <= cur_a;
      b_q   <= cur_b;
      off_q <= cur_off;
    end
  end

  // Stage 1: classify the slot and fold it onto i<=j.
  logic [ANT_BITS-1:0] diff, lo, hi;
  logic                conj, drop;
  logic [BL_BITS-1:0]  tri_addr;
  logic [DATA_W-1:0]   re_in, im_in, im_out;

  assign diff     = cur_a - cur_b;
  assign conj     = cur_a > cur_b;
  assign drop     = (diff == ANT_HALF) && (cur_b >= ANT_HALF);
  assign lo       = conj ? cur_b : cur_a;
  assign hi       = conj ? cur_a : cur_b;
  assign tri_addr = BL_BITS'(tri_idx(32'(hi))) + BL_BITS'(lo);
  assign re_in    = in_data[2*DATA_W-1:DATA_W];
  assign im_in    = in_data[DATA_W-1:0];
  // The most negative im has no positive twin; clamp instead of wrapping.
  assign im_out   = !conj ? im_in : ((im_in == IM_MIN) ? IM_MAX : -im_in);

  logic                s1_valid, s1_drop, s1_last;
  logic [BL_BITS-1:0]  s1_addr;
  logic [2*DATA_W-1:0] s1_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_drop  <= 1'b0;
      s1_last  <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_drop <= drop;
        s1_last <= (cur_a == ANT_MAX) && (cur_b == ANT_MAX);
        s1_addr <= tri_addr;
        s1_data <= {re_in, im_out};
      end
    end
  end

  // Stage 2: bank write; sync squashes an in-flight write so a partial frame never completes.
  logic wr_en, frame_done, wr_bank_q;

  assign wr_en      = s1_valid && !s1_drop && !sync;
  assign frame_done = s1_valid && s1_last && !sync;

  rd_state_e           rd_state_q;
  logic                rd_bank_q, ovf_q, rd_run;
  logic [BL_BITS-1:0]  rd_addr_q;
  logic [ANT_BITS-1:0] rd_i_q, rd_j_q;

  assign rd_run  = (rd_state_q == RdRun);
  assign ovf_err = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q  <= 1'b0;
      rd_state_q <= RdIdle;
      rd_bank_q  <= 1'b0;
      rd_addr_q  <= '0;
      rd_i_q     <= '0;
      rd_j_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (frame_done) wr_bank_q <= ~wr_bank_q;
      if (sync) begin
        rd_state_q <= RdIdle;
      end else if (frame_done) begin
        if (rd_run) ovf_q <= 1'b1;
        rd_state_q <= RdRun;
        rd_bank_q  <= wr_bank_q;
        rd_addr_q  <= '0;
        rd_i_q     <= '0;
        rd_j_q     <= '0;
      end else if (rd_run) begin
        if (rd_addr_q == BL_LAST) begin
          rd_state_q <= RdIdle;
        end else begin
          rd_addr_q <= rd_addr_q + BL_ONE;
          if (rd_i_q == rd_j_q) begin
            rd_i_q <= '0;
            rd_j_q <= rd_j_q + ANT_ONE;
          end else begin
            rd_i_q <= rd_i_q + ANT_ONE;
          end
        end
      end
    end
  end

  logic [2*DATA_W-1:0] ram_rdata;

  bl_reorder_ram #(
    .DEPTH (RAM_DEPTH),
    .WIDTH (2 * DATA_W),
    .AW    (RAM_AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (bank_addr(wr_bank_q, s1_addr)),
    .wr_data (s1_data),
    .rd_en   (rd_run),
    .rd_addr (bank_addr(rd_bank_q, rd_addr_q)),
    .rd_data (ram_rdata)
  );

  // Tags travel alongside the RAM read latency, then everything lands in resettable regs.
  logic                rv1_q, rl1_q, emit;
  logic [ANT_BITS-1:0] ri1_q, rj1_q;

  assign emit = rv1_q && !sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv1_q     <= 1'b0;
      rl1_q     <= 1'b0;
      ri1_q     <= '0;
      rj1_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ant_i <= '0;
      out_ant_j <= '0;
      out_last  <= 1'b0;
    end else begin
      rv1_q     <= rd_run && !sync;
      rl1_q     <= rd_run && (rd_addr_q == BL_LAST);
      ri1_q     <= rd_i_q;
      rj1_q     <= rd_j_q;
      out_valid <= emit;
      out_data  <= emit ? ram_rdata : '0;
      out_ant_i <= emit ? ri1_q : '0;
      out_ant_j <= emit ? rj1_q : '0;
      out_last  <= emit && rl1_q;
    end
  end

endmodule

// File: tb/tb_bl_order_reorder.sv
// Directed bench for bl_order_reorder: a 4-antenna instance for ordering, timing, saturation,
// sync and reset cases, and a 16-antenna instance for back-to-back frames.
module tb_bl_order_reorder;

  typedef struct {
    logic [35:0] d;
    logic [3:0]  i;
    logic [3:0]  j;
    logic        last;
    int          cyc;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sync = 1'b0;
  logic        in_valid = 1'b0;
  logic [35:0] in_data = '0;

  logic        ov4, ol4, ovf4, ov16, ol16, ovf16;
  logic [35:0] od4, od16;
  logic [1:0]  oi4, oj4;
  logic [3:0]  oi16, oj16;

  bl_order_reorder #(.N_ANTS(4), .DATA_W(18)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .sync      (sync),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (ov4),
    .out_data  (od4),
    .out_ant_i (oi4),
    .out_ant_j (oj4),
    .out_last  (ol4),
    .ovf_err   (ovf4)
  );

  bl_order_reorder #(.N_ANTS(16), .DATA_W(18)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .sync      (sync),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (ov16),
    .out_data  (od16),
    .out_ant_i (oi16),
    .out_ant_j (oj16),
    .out_last  (ol16),
    .ovf_err   (ovf16)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rec_t q4[$];
  rec_t q16[$];

  always @(negedge clk) begin
    rec_t r;
    if (ov4 === 1'b1) begin
      r.d = od4; r.i = {2'b00, oi4}; r.j = {2'b00, oj4}; r.last = ol4; r.cyc = cyc;
      q4.push_back(r);
    end
    if (ov16 === 1'b1) begin
      r.d = od16; r.i = oi16; r.j = oj16; r.last = ol16; r.cyc = cyc;
      q16.push_back(r);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int last_in_cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic s, input logic v, input logic [35:0] d);
    sync = s;
    in_valid = v;
    in_data = d;
    if (v) last_in_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0);
  endtask

  function automatic logic [35:0] pk(input int re, input int im);
    return {18'(re), 18'(im)};
  endfunction

  task automatic frame4();
    step(1'b1, 1'b0, '0);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1, pk(k, k));
  endtask

  // Hand-derived canonical replay of a 4-antenna frame whose slot k carries re=im=k.
  task automatic check_frame4(input string pfx);
    int re_tab[10];
    int i_tab[10];
    int j_tab[10];
    bit cj_tab[10];
    logic [17:0] r18;
    re_tab = '{2, 4, 5, 0, 7, 8, 1, 3, 10, 11};
    i_tab  = '{0, 0, 1, 0, 1, 2, 0, 1, 2, 3};
    j_tab  = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
    cj_tab = '{0, 0, 0, 1, 0, 0, 1, 1, 0, 0};
    check({pfx, "_count"}, 64'(q4.size()), 64'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < q4.size()) begin
        r18 = 18'(re_tab[k]);
        check($sformatf("%s_data%0d", pfx, k), 64'(q4[k].d),
              64'({r18, cj_tab[k] ? -r18 : r18}));
        check($sformatf("%s_ij%0d", pfx, k), 64'({q4[k].i, q4[k].j}),
              64'({4'(i_tab[k]), 4'(j_tab[k])}));
        check($sformatf("%s_last%0d", pfx, k), 64'(q4[k].last), 64'(k == 9));
        check($sformatf("%s_cyc%0d", pfx, k), 64'(q4[k].cyc), 64'(last_in_cyc + 4 + k));
      end
    end
    q4.delete();
  endtask

  // Independent closed form of the generator order: row b visits a=(b+N/2+t) mod N, t=0..N/2.
  function automatic int t_of(input int a, input int b);
    return ((a - b - 8) % 16 + 16) % 16;
  endfunction

  function automatic bit dup16(input int a, input int b);
    return (((a - b) % 16 + 16) % 16 == 8) && (b >= 8);
  endfunction

  int ti[136];
  int tj[136];
  int tslot[136];
  bit tconj[136];
  int fend[3];

  initial begin
    int idx;
    int t;
    logic [17:0] s18;

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'({ov4, ov16}), 64'd0);
    check("rst_data", 64'(od4), 64'd0);
    check("rst_ij", 64'({oi4, oj4}), 64'd0);
    check("rst_last", 64'({ol4, ol16}), 64'd0);
    check("rst_ovf", 64'({ovf4, ovf16}), 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ordering, conjugation, last flag and latency of one frame.
    frame4();
    idle(20);
    check_frame4("t1");

    // Saturating conjugate of the most negative imaginary part at slot (a=2,b=0).
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, {18'd0, 18'h20000});
    for (int k = 1; k < 12; k++) step(1'b0, 1'b1, pk(k, k));
    idle(20);
    check("t4_count", 64'(q4.size()), 64'd10);
    if (q4.size() > 3) begin
      check("t4_sat", 64'(q4[3].d), 64'({18'd0, 18'h1FFFF}));
      check("t4_ij", 64'({q4[3].i, q4[3].j}), 64'h02);
    end
    q4.delete();

    // Partial frame discarded by a mid-frame sync.
    step(1'b1, 1'b0, '0);
    for (int k = 0; k < 7; k++) step(1'b0, 1'b1, pk(100 + k, 100 + k));
    frame4();
    idle(20);
    check_frame4("t5");

    // Sync during a readout stops out_valid on the next clock.
    frame4();
    idle(5);
    check("t5_mid_valid", 64'(ov4), 64'd1);
    step(1'b1, 1'b0, '0);
    check("t5_abort", 64'(ov4), 64'd0);
    idle(15);
    check("t5_abort_count", 64'(q4.size()), 64'd3);
    check("t5_ovf", 64'(ovf4), 64'd0);
    q4.delete();

    // Asynchronous reset in the middle of a readout.
    frame4();
    idle(5);
    check("t6_pre_valid", 64'(ov4), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", 64'(ov4), 64'd0);
    check("t6_data", 64'(od4), 64'd0);
    check("t6_ij", 64'({oi4, oj4}), 64'd0);
    check("t6_last", 64'(ol4), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    q4.delete();
    frame4();
    idle(20);
    check_frame4("t6");

    // 16 antennas, three back-to-back frames, first sample arriving together with sync.
    idx = 0;
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i <= j; i++) begin
        ti[idx] = i;
        tj[idx] = j;
        t = t_of(j, i);
        if (i != j && t <= 8 && !dup16(j, i)) begin
          tslot[idx] = i * 9 + t;
          tconj[idx] = 1'b1;
        end else begin
          tslot[idx] = j * 9 + t_of(i, j);
          tconj[idx] = 1'b0;
        end
        idx++;
      end
    end
    q16.delete();
    for (int k = 0; k < 432; k++) begin
      step(k == 0, 1'b1, pk(k % 144, k % 144));
      if (k % 144 == 143) fend[k / 144] = last_in_cyc;
    end
    idle(160);
    check("t3_count", 64'(q16.size()), 64'd408);
    for (int n = 0; n < 408; n++) begin
      if (n < q16.size()) begin
        idx = n % 136;
        s18 = 18'(tslot[idx]);
        check($sformatf("t3_f%0d_k%0d", n / 136, idx),
              64'({q16[n].last, q16[n].i, q16[n].j, q16[n].d}),
              64'({idx == 135, 4'(ti[idx]), 4'(tj[idx]), s18, tconj[idx] ? -s18 : s18}));
      end
    end
    for (int f = 0; f < 3; f++) begin
      if (f * 136 < q16.size())
        check($sformatf("t3_start%0d", f), 64'(q16[f * 136].cyc), 64'(fend[f] + 4));
    end
    check("t3_ovf", 64'({ovf4, ovf16}), 64'd0);
    q4.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
